uart_tx_arbiter: RTL and testbench

Shares one UART transmitter among NREQ byte requesters, such as key-press codes and the receive-echo path, using round-robin arbitration. Each requester has a one-byte holding slot with a valid/ready handshake. The block sequences the transmitter with a start/busy handshake and flags transmitter stalls. It sits between the requesting logic and uart_hs, replacing ad-hoc priority muxing of uart_send/uart_data_in.

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one UART transmitter among NREQ byte
//               requesters. Each requester owns a one-byte holding slot with
//               a valid/ready handshake. The transmitter is driven through a
//               start pulse and watched through its busy flag; a transmitter
//               that never goes busy raises a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int START_WAIT = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    active,
    output logic                    err,
    input  logic                    err_clr
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(START_WAIT) + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NREQ-1:0]        full_q, full_d;
    logic [NREQ-1:0][7:0]   slot_q, slot_d;
    logic [IW-1:0]          last_q, last_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   tx_start_q, tx_start_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   err_q, err_d;

    logic                   pick_found;
    logic [IW-1:0]          pick_idx;
    logic [IW:0]            rr_sum;

    assign req_ready = ~full_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_q;
    assign active    = (state_q != S_IDLE);
    assign err       = err_q;

    // Round-robin search: first full slot after the last served one, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            rr_sum = {1'b0, last_q} + (IW+1)'(off);
            if (rr_sum >= (IW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IW+1)'(NREQ);
            end
            if (!pick_found && full_q[rr_sum[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = rr_sum[IW-1:0];
            end
        end
    end

    // Next-state logic: slot acceptance, sequencing FSM and sticky error.
    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        slot_d     = slot_q;
        last_d     = last_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        err_d      = err_q;

        // Clear first so that a timeout in the same cycle overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        // A full slot never accepts, so a slot being freed this cycle stays empty.
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !full_q[i]) begin
                full_d[i] = 1'b1;
                slot_d[i] = req_data[8*i +: 8];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_start_d      = 1'b1;
                tx_data_d       = slot_q[grant_q];
                full_d[grant_q] = 1'b0;
                last_d          = grant_q;
                cnt_d           = '0;
                state_d         = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(START_WAIT - 1)) begin
                    // Transmitter never responded: drop the byte, no retry.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; the rr pointer resets to NREQ-1 so requester 0 goes first.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            full_q     <= '0;
            slot_q     <= '0;
            last_q     <= IW'(NREQ - 1);
            grant_q    <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            full_q     <= full_d;
            slot_q     <= slot_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter: vector table,
//               directed corner sequences and randomized traffic against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int SW   = 8;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy   = 1'b0;
    logic [1:0]        grant_id;
    logic              active;
    logic              err;
    logic              err_clr   = 1'b0;

    uart_tx_arbiter #(.NREQ(NREQ), .START_WAIT(SW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slot contents, rr pointer, and the transaction in flight.
    bit         m_full [NREQ];
    logic [7:0] m_data [NREQ];
    int         m_last;
    int         m_cnt;      // edges until the predicted tx_start (0: none scheduled)
    int         m_pick;
    int         m_grant;
    int         m_wait;     // cycles spent waiting for busy (-1: not waiting)
    bit         m_frame;
    bit         m_err;
    logic [7:0] m_txd;

    // Transmitter stand-in.
    bit stall = 1'b0;
    int xd = 0;
    int xl = 0;

    int         gq [$];
    logic [7:0] dq [$];

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          n;
        logic [7:0]  ord;   // 2-bit expected grant indices, first at [1:0]
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick();
        for (int off = 1; off <= NREQ; off++) begin
            if (m_full[(m_last + off) % NREQ]) return (m_last + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic int getg(input int j);
        return (j < gq.size()) ? gq[j] : -1;
    endfunction

    function automatic logic [7:0] getd(input int j);
        return (j < dq.size()) ? dq[j] : 8'hxx;
    endfunction

    function automatic vec_t mk(input logic [3:0] m, input logic [31:0] d, input int n,
                                input int o0, input int o1, input int o2, input int o3);
        vec_t v;
        v.mask = m;
        v.data = d;
        v.n    = n;
        v.ord  = {o3[1:0], o2[1:0], o1[1:0], o0[1:0]};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = 8'h00;
        end
        m_last  = NREQ - 1;
        m_cnt   = 0;
        m_pick  = 0;
        m_grant = 0;
        m_wait  = -1;
        m_frame = 1'b0;
        m_err   = 1'b0;
        m_txd   = 8'h00;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_valid = '0;
        err_clr   = 1'b0;
        tx_busy   = 1'b0;
        xd        = 0;
        xl        = 0;
        model_reset();
        gq.delete();
        dq.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_ready", req_ready, 4'hF);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_active", active, 0);
        check("rst_err", err, 0);
        sys_rst_n = 1'b1;
    endtask

    // One clock: advance the model over the edge, compare every output, drive the transmitter.
    task automatic cycle();
        logic [NREQ-1:0]   v;
        logic [8*NREQ-1:0] d;
        logic              b;
        logic              c;
        logic [NREQ-1:0]   er;
        bit                set_err;
        bit                exp_start;
        v = req_valid;
        d = req_data;
        b = tx_busy;
        c = err_clr;
        set_err   = 1'b0;
        exp_start = 1'b0;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && !m_full[i]) begin
                m_full[i] = 1'b1;
                m_data[i] = d[8*i +: 8];
            end
        end
        if (m_cnt == 2) begin
            m_cnt   = 1;
            m_grant = m_pick;
        end else if (m_cnt == 1) begin
            m_cnt           = 0;
            m_txd           = m_data[m_grant];
            m_full[m_grant] = 1'b0;
            m_last          = m_grant;
            m_wait          = 0;
            exp_start       = 1'b1;
        end else if (m_wait >= 0) begin
            if (b) begin
                m_wait  = -1;
                m_frame = 1'b1;
            end else if (m_wait == SW - 1) begin
                m_wait  = -1;
                m_err   = 1'b1;
                set_err = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (m_frame) begin
            if (!b) m_frame = 1'b0;
        end
        if (c && !set_err) m_err = 1'b0;
        if (m_cnt == 0 && m_wait < 0 && !m_frame && rr_pick() >= 0) begin
            m_pick = rr_pick();
            m_cnt  = 2;
        end

        for (int i = 0; i < NREQ; i++) er[i] = !m_full[i];
        check("req_ready", req_ready, er);
        check("tx_start", tx_start, exp_start);
        check("tx_data", tx_data, m_txd);
        check("grant_id", grant_id, m_grant);
        check("active", active, (m_cnt == 1) || (m_wait >= 0) || m_frame);
        check("err", err, m_err);

        if (tx_start) begin
            gq.push_back(int'(grant_id));
            dq.push_back(tx_data);
        end

        if (tx_start && !stall) xd = $urandom_range(1, 3);
        if (xd > 0) begin
            xd--;
            if (xd == 0) begin
                tx_busy = 1'b1;
                xl      = $urandom_range(3, 12);
            end
        end else if (xl > 0) begin
            xl--;
            if (xl == 0) tx_busy = 1'b0;
        end
    endtask

    task automatic wait_starts(input int n);
        int k;
        k = 0;
        while (gq.size() < n && k < 300) begin
            cycle();
            k++;
        end
        check("start_count", gq.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        tbl[0] = mk(4'b0100, 32'h0033_0000, 1, 2, 0, 0, 0);
        tbl[1] = mk(4'b1011, 32'h4400_2211, 3, 0, 1, 3, 0);
        tbl[2] = mk(4'b1111, 32'hDDCC_BBAA, 4, 0, 1, 2, 3);
        tbl[3] = mk(4'b1000, 32'h7700_0000, 1, 3, 0, 0, 0);
        tbl[4] = mk(4'b0110, 32'h0099_8800, 2, 1, 2, 0, 0);

        // Vector table: one load from reset, then grant order, bytes and first-start latency.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            req_valid = tbl[t].mask;
            req_data  = tbl[t].data;
            cycle();
            req_valid = '0;
            lat = 0;
            while (gq.size() == 0 && lat < 100) begin
                cycle();
                lat++;
            end
            check("start_latency", lat, 2);
            wait_starts(tbl[t].n);
            for (int j = 0; j < tbl[t].n; j++) begin
                check("tbl_grant", getg(j), int'(tbl[t].ord[2*j +: 2]));
                check("tbl_data", getd(j), tbl[t].data[8*tbl[t].ord[2*j +: 2] +: 8]);
            end
        end

        // Reload 0 and 3 while 3 is sending: 0 goes before 3.
        do_reset();
        req_valid = 4'b1011;
        req_data  = 32'h4400_2211;
        cycle();
        req_valid = '0;
        wait_starts(3);
        check("reload_g2", getg(2), 3);
        req_valid = 4'b1001;
        req_data  = 32'h6600_0055;
        cycle();
        req_valid = '0;
        wait_starts(5);
        check("reload_g3", getg(3), 0);
        check("reload_d3", getd(3), 8'h55);
        check("reload_g4", getg(4), 3);
        check("reload_d4", getd(4), 8'h66);

        // Requester 0 refilling continuously cannot starve requester 1.
        do_reset();
        req_valid = 4'b0011;
        req_data  = 32'h0000_3CA5;
        cycle();
        req_valid = 4'b0001;
        wait_starts(3);
        req_valid = '0;
        check("fair_g0", getg(0), 0);
        check("fair_g1", getg(1), 1);
        check("fair_d1", getd(1), 8'h3C);
        check("fair_g2", getg(2), 0);
        check("fair_d2", getd(2), 8'hA5);

        // Stall: err exactly START_WAIT cycles after tx_start, next slot still issued, err_clr.
        do_reset();
        stall     = 1'b1;
        req_valid = 4'b0110;
        req_data  = 32'h0034_1200;
        cycle();
        req_valid = '0;
        wait_starts(1);
        check("stall_g0", getg(0), 1);
        n = 0;
        while (!err && n < 100) begin
            cycle();
            n++;
        end
        check("stall_err_delay", n, SW);
        wait_starts(2);
        check("stall_g1", getg(1), 2);
        check("stall_d1", getd(1), 8'h34);
        n = 0;
        while (active && n < 100) begin
            cycle();
            n++;
        end
        check("stall_err_held", err, 1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("err_clr", err, 0);
        stall = 1'b0;

        // Backpressure: a full slot keeps its byte while valid stays high with new data.
        do_reset();
        req_valid = 4'b0011;
        req_data  = 32'h0000_5A01;
        cycle();
        req_valid = 4'b0010;
        req_data  = 32'h0000_E700;
        n = 0;
        while (gq.size() < 2 && n < 300) begin
            cycle();
            n++;
            if (gq.size() < 2) check("bp_ready1", req_ready[1], 0);
        end
        check("bp_g1", getg(1), 1);
        check("bp_d1", getd(1), 8'h5A);
        cycle();
        req_valid = '0;
        wait_starts(3);
        check("bp_g2", getg(2), 1);
        check("bp_d2", getd(2), 8'hE7);

        // Reset during a frame with another slot still pending.
        do_reset();
        req_valid = 4'b1100;
        req_data  = 32'h3B2B_0000;
        cycle();
        req_valid = '0;
        n = 0;
        while (!(tx_busy && active) && n < 100) begin
            cycle();
            n++;
        end
        cycle();
        check("mid_pending", req_ready, 4'b0111);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_ready", req_ready, 4'hF);
        check("arst_active", active, 0);
        check("arst_tx_start", tx_start, 0);
        do_reset();
        repeat (20) cycle();
        check("no_stale_start", gq.size(), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 0) stall = ($urandom_range(0, 3) == 0);
            req_valid = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            req_data  = $urandom;
            err_clr   = ($urandom_range(0, 15) == 0);
            cycle();
        end
        req_valid = '0;
        err_clr   = 1'b0;
        stall     = 1'b0;
        n = 0;
        while ((active || req_ready != 4'hF) && n < 400) begin
            cycle();
            n++;
        end
        check("drain_ready", req_ready, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
